// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: powers the PLL up, debounces its lock, and re-powers
// it on lock loss with a bounded number of retries before latching a fault.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for device init to complete
// POWERDOWN    | PLL held in powerdown for PD_CYCLES
// WAIT_LOCK    | PLL released, waiting for synced lock, timeout running
// DEBOUNCE     | lock seen, counting consecutive high cycles
// RUN          | lock qualified, fabric reset released
// FAULT        | retries exhausted, absorbing until reset
module pll_lock_supervisor #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned PD_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned STABLE_CYCLES = 64,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PLL_LOCK,
    input  logic       INIT_DONE,
    input  logic       FORCE_RELOCK,
    output logic       PLL_POWERDOWN_N,
    output logic       FABRIC_RESET_N,
    output logic       LOCK_OK,
    output logic       FAULT,
    output logic [3:0] RETRY_COUNT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_POWERDOWN = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_DEBOUNCE  = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] PD_LAST    = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] STABLE_TC  = CNT_W'(STABLE_CYCLES);
    localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRY);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       timer_q, timer_d;
    logic [CNT_W-1:0]       stable_q, stable_d;
    logic [3:0]             retry_q, retry_d;
    logic [SYNC_STAGES-1:0] sync_lk_q, sync_lk_d;
    logic [SYNC_STAGES-1:0] sync_id_q, sync_id_d;

    logic             lk, id;
    logic [CNT_W-1:0] tmr_inc, stable_inc;
    logic             timeout;
    logic             retry_evt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            stable_q  <= '0;
            retry_q   <= '0;
            sync_lk_q <= '0;
            sync_id_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            stable_q  <= stable_d;
            retry_q   <= retry_d;
            sync_lk_q <= sync_lk_d;
            sync_id_q <= sync_id_d;
        end
    end

    assign lk         = sync_lk_q[SYNC_STAGES-1];
    assign id         = sync_id_q[SYNC_STAGES-1];
    assign tmr_inc    = timer_q + CNT_W'(1);
    assign stable_inc = stable_q + CNT_W'(1);
    // Timeout spans WAIT_LOCK and DEBOUNCE together, measured from powerdown exit.
    assign timeout    = (tmr_inc >= TIMEOUT);

    always_comb begin
        sync_lk_d = {sync_lk_q[SYNC_STAGES-2:0], PLL_LOCK};
        sync_id_d = {sync_id_q[SYNC_STAGES-2:0], INIT_DONE};
        state_d   = state_q;
        timer_d   = timer_q;
        stable_d  = stable_q;
        retry_d   = retry_q;
        retry_evt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (id) begin
                    state_d = ST_POWERDOWN;
                    timer_d = '0;
                end
            end
            ST_POWERDOWN: begin
                if (timer_q >= PD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = tmr_inc;
                end
            end
            ST_WAIT_LOCK: begin
                timer_d = tmr_inc;
                if (lk) begin
                    if (STABLE_CYCLES <= 1) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                        timer_d = '0;
                    end else begin
                        state_d  = ST_DEBOUNCE;
                        stable_d = CNT_W'(1);
                    end
                end else if (timeout) begin
                    retry_evt = 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                timer_d = tmr_inc;
                if (timeout) begin
                    retry_evt = 1'b1;
                end else if (!lk) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stable_inc >= STABLE_TC) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                    timer_d = '0;
                end else begin
                    stable_d = stable_inc;
                end
            end
            ST_RUN: begin
                if (!lk) begin
                    retry_evt = 1'b1;
                end else if (FORCE_RELOCK) begin
                    state_d = ST_POWERDOWN;
                    timer_d = '0;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        if (retry_evt) begin
            if (retry_q == RETRY_LAST) begin
                state_d = ST_FAULT;
            end else begin
                retry_d = retry_q + 4'd1;
                state_d = ST_POWERDOWN;
                timer_d = '0;
            end
        end
    end

    assign PLL_POWERDOWN_N = !(state_q inside {ST_IDLE, ST_POWERDOWN, ST_FAULT});
    assign FABRIC_RESET_N  = (state_q == ST_RUN);
    assign LOCK_OK         = (state_q == ST_RUN);
    assign FAULT           = (state_q == ST_FAULT);
    assign RETRY_COUNT     = retry_q;
    assign STATE           = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus a random
// soak, all compared every cycle against a phase-level behavioural model.
module tb_pll_lock_supervisor;

    localparam int SYNC = 2;
    localparam int PDC  = 4;
    localparam int TMO  = 32;
    localparam int STB  = 8;
    localparam int MAXR = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PLL_LOCK = 1'b0;
    logic       INIT_DONE = 1'b0;
    logic       FORCE_RELOCK = 1'b0;
    logic       PLL_POWERDOWN_N, FABRIC_RESET_N, LOCK_OK, FAULT;
    logic [3:0] RETRY_COUNT;
    logic [2:0] STATE;

    pll_lock_supervisor #(
        .SYNC_STAGES(SYNC), .PD_CYCLES(PDC), .LOCK_TIMEOUT(TMO),
        .STABLE_CYCLES(STB), .MAX_RETRY(MAXR), .CNT_W(16)
    ) dut (
        .CLK(CLK), .RST(RST), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
        .FORCE_RELOCK(FORCE_RELOCK), .PLL_POWERDOWN_N(PLL_POWERDOWN_N),
        .FABRIC_RESET_N(FABRIC_RESET_N), .LOCK_OK(LOCK_OK), .FAULT(FAULT),
        .RETRY_COUNT(RETRY_COUNT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    // Model phases: the lock window merges waiting and debouncing; a nonzero
    // run of consecutive lock cycles means "debouncing".
    localparam int P_IDLE = 0, P_PD = 1, P_WIN = 2, P_RUN = 3, P_FAULT = 4;
    int m_phase, m_age, m_run, m_retry;
    bit lk_hist[$];
    bit id_hist[$];

    function automatic logic [10:0] obs_vec();
        return {PLL_POWERDOWN_N, FABRIC_RESET_N, LOCK_OK, FAULT, RETRY_COUNT, STATE};
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [2:0] st;
        case (m_phase)
            P_IDLE:  st = 3'd0;
            P_PD:    st = 3'd1;
            P_WIN:   st = (m_run > 0) ? 3'd3 : 3'd2;
            P_RUN:   st = 3'd4;
            default: st = 3'd5;
        endcase
        return {(m_phase == P_WIN || m_phase == P_RUN), (m_phase == P_RUN),
                (m_phase == P_RUN), (m_phase == P_FAULT), 4'(m_retry), st};
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_age = 0; m_run = 0; m_retry = 0;
        lk_hist.delete(); id_hist.delete();
        repeat (SYNC) begin lk_hist.push_back(1'b0); id_hist.push_back(1'b0); end
    endtask

    task automatic model_retry();
        m_run = 0;
        if (m_retry == MAXR) m_phase = P_FAULT;
        else begin m_retry++; m_phase = P_PD; m_age = 0; end
    endtask

    task automatic model_edge();
        bit lk, id;
        if (RST) begin model_reset(); return; end
        lk = lk_hist.pop_front(); lk_hist.push_back(PLL_LOCK);
        id = id_hist.pop_front(); id_hist.push_back(INIT_DONE);
        case (m_phase)
            P_IDLE: if (id) begin m_phase = P_PD; m_age = 0; end
            P_PD: begin
                m_age++;
                if (m_age == PDC) begin m_phase = P_WIN; m_age = 0; m_run = 0; end
            end
            P_WIN: begin
                m_age++;
                if (m_run == 0) begin
                    if (lk) m_run = 1;
                    else if (m_age >= TMO) model_retry();
                end else if (m_age >= TMO) model_retry();
                else if (!lk) m_run = 0;
                else begin
                    m_run++;
                    if (m_run >= STB) begin m_phase = P_RUN; m_retry = 0; m_run = 0; end
                end
            end
            P_RUN: begin
                if (!lk) model_retry();
                else if (FORCE_RELOCK) begin m_phase = P_PD; m_age = 0; end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; INIT_DONE = 1'b0; PLL_LOCK = 1'b0; FORCE_RELOCK = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (obs_vec() !== 11'b0) begin
            n_fail++; $display("FAIL reset_outputs got=%b exp=%b", obs_vec(), 11'b0);
        end
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model got=%b exp=%b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_bringup();
        int pd_len = 0;
        int t_run = -1;
        RST = 1'b1; INIT_DONE = 1'b1; PLL_LOCK = 1'b1;
        tick(); tick();
        RST = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL bringup_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            if (STATE == 3'd1 && PLL_POWERDOWN_N == 1'b0) pd_len++;
            if (STATE == 3'd4 && t_run < 0) t_run = i;
        end
        n_cmp++;
        if (pd_len != PDC) begin n_fail++; $display("FAIL bringup_pd_len got=%0d exp=%0d", pd_len, PDC); end
        n_cmp++;
        if (t_run != 15) begin n_fail++; $display("FAIL bringup_run_edge got=%0d exp=15", t_run); end
        n_cmp++;
        if (obs_vec() !== {4'b1110, 4'd0, 3'd4}) begin
            n_fail++; $display("FAIL bringup_run_outputs got=%b exp=%b", obs_vec(), {4'b1110, 4'd0, 3'd4});
        end
    endtask

    task automatic test_init_gating();
        int t_pd = -1;
        RST = 1'b1; INIT_DONE = 1'b0; PLL_LOCK = 1'b1;
        tick(); tick();
        RST = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_cmp++;
            if (STATE !== 3'd0 || PLL_POWERDOWN_N !== 1'b0) begin
                n_fail++; $display("FAIL init_gate_idle cyc=%0d state=%0d pdn=%b exp state=0 pdn=0", i, STATE, PLL_POWERDOWN_N);
            end
        end
        INIT_DONE = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL init_gate_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            if (STATE == 3'd1 && t_pd < 0) t_pd = i;
        end
        n_cmp++;
        if (t_pd != 3) begin n_fail++; $display("FAIL init_gate_pd_edge got=%0d exp=3", t_pd); end
        n_cmp++;
        if (STATE !== 3'd4) begin n_fail++; $display("FAIL init_gate_run got=%0d exp=4", STATE); end
    endtask

    task automatic test_lock_loss();
        logic exp_frn [3] = '{1'b1, 1'b1, 1'b0};
        PLL_LOCK = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (FABRIC_RESET_N !== exp_frn[i] || LOCK_OK !== exp_frn[i]) begin
                n_fail++; $display("FAIL lockloss_latency edge=k+%0d frn=%b lok=%b exp=%b", i, FABRIC_RESET_N, LOCK_OK, exp_frn[i]);
            end
        end
        n_cmp++;
        if (STATE !== 3'd1 || RETRY_COUNT !== 4'd1) begin
            n_fail++; $display("FAIL lockloss_retry state=%0d retry=%0d exp state=1 retry=1", STATE, RETRY_COUNT);
        end
        repeat (3) tick();
        PLL_LOCK = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL lockloss_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (STATE !== 3'd4 || RETRY_COUNT !== 4'd0) begin
            n_fail++; $display("FAIL lockloss_relock state=%0d retry=%0d exp state=4 retry=0", STATE, RETRY_COUNT);
        end
    endtask

    task automatic test_chatter_timeout();
        int win = 0;
        int first_win = -1;
        bit seen_run = 1'b0;
        bit seen_deb = 1'b0;
        FORCE_RELOCK = 1'b1; tick(); FORCE_RELOCK = 1'b0;
        n_cmp++;
        if (STATE !== 3'd1 || RETRY_COUNT !== 4'd0) begin
            n_fail++; $display("FAIL force_run state=%0d retry=%0d exp state=1 retry=0", STATE, RETRY_COUNT);
        end
        for (int i = 0; i < 118; i++) begin
            if (i % 5 == 0) PLL_LOCK = ~PLL_LOCK;
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL chatter_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            if (STATE == 3'd2 || STATE == 3'd3) win++;
            else if (STATE == 3'd1 && win > 0 && first_win < 0) first_win = win;
            if (STATE == 3'd3) seen_deb = 1'b1;
            if (STATE == 3'd4) seen_run = 1'b1;
        end
        n_cmp++;
        if (seen_run !== 1'b0) begin n_fail++; $display("FAIL chatter_no_run got=%b exp=0", seen_run); end
        n_cmp++;
        if (seen_deb !== 1'b1) begin n_fail++; $display("FAIL chatter_debounce got=%b exp=1", seen_deb); end
        n_cmp++;
        if (first_win != TMO) begin n_fail++; $display("FAIL chatter_timeout_len got=%0d exp=%0d", first_win, TMO); end
        n_cmp++;
        if (FAULT !== 1'b1 || STATE !== 3'd5 || PLL_POWERDOWN_N !== 1'b0) begin
            n_fail++; $display("FAIL chatter_fault fault=%b state=%0d pdn=%b exp 1/5/0", FAULT, STATE, PLL_POWERDOWN_N);
        end
        PLL_LOCK = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_cmp++;
            if (FAULT !== 1'b1 || STATE !== 3'd5) begin
                n_fail++; $display("FAIL fault_sticky cyc=%0d fault=%b state=%0d exp 1/5", i, FAULT, STATE);
            end
        end
    endtask

    task automatic test_force_relock();
        RST = 1'b1; INIT_DONE = 1'b1; PLL_LOCK = 1'b1;
        tick(); tick();
        RST = 1'b0;
        repeat (20) tick();
        n_cmp++;
        if (STATE !== 3'd4) begin n_fail++; $display("FAIL force_bringup got=%0d exp=4", STATE); end
        FORCE_RELOCK = 1'b1; tick(); FORCE_RELOCK = 1'b0;
        n_cmp++;
        if (STATE !== 3'd1 || RETRY_COUNT !== 4'd0) begin
            n_fail++; $display("FAIL force_lock_high state=%0d retry=%0d exp state=1 retry=0", STATE, RETRY_COUNT);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL force_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
        PLL_LOCK = 1'b0;
        tick(); tick();
        FORCE_RELOCK = 1'b1; tick(); FORCE_RELOCK = 1'b0;
        n_cmp++;
        if (STATE !== 3'd1 || RETRY_COUNT !== 4'd1) begin
            n_fail++; $display("FAIL force_with_loss state=%0d retry=%0d exp state=1 retry=1", STATE, RETRY_COUNT);
        end
        repeat (4) tick();
        FORCE_RELOCK = 1'b1; tick(); FORCE_RELOCK = 1'b0;
        n_cmp++;
        if (STATE !== 3'd2 || RETRY_COUNT !== 4'd1) begin
            n_fail++; $display("FAIL force_in_wait state=%0d retry=%0d exp state=2 retry=1", STATE, RETRY_COUNT);
        end
        PLL_LOCK = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL force_relock_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (STATE !== 3'd4 || RETRY_COUNT !== 4'd0) begin
            n_fail++; $display("FAIL force_not_queued state=%0d retry=%0d exp state=4 retry=0", STATE, RETRY_COUNT);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        PLL_LOCK = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_mid_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            if (STATE == 3'd1 && RETRY_COUNT == 4'd2) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL reset_mid_reach got=%0d/%0d exp=1/2", STATE, RETRY_COUNT); end
        RST = 1'b1; tick(); RST = 1'b0;
        n_cmp++;
        if (obs_vec() !== 11'b0) begin
            n_fail++; $display("FAIL reset_mid_outputs got=%b exp=%b", obs_vec(), 11'b0);
        end
        tick();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_mid_after got=%b exp=%b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int hold = 0;
        int fault_len = 0;
        RST = 1'b1; INIT_DONE = 1'b1; FORCE_RELOCK = 1'b0;
        tick();
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                PLL_LOCK = ($urandom_range(0, 3) != 0);
                hold = PLL_LOCK ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 12));
            end
            hold--;
            FORCE_RELOCK = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) INIT_DONE = ~INIT_DONE;
            RST = ($urandom_range(0, 699) == 0) || (fault_len > 60);
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_model cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            fault_len = FAULT ? fault_len + 1 : 0;
        end
        RST = 1'b0; FORCE_RELOCK = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_bringup();
        test_init_gating();
        test_lock_loss();
        test_chatter_timeout();
        test_force_relock();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
